// File: rtl/tv80_alu16_seq_pkg.sv
// tv80_alu16_seq_pkg
//   Shared definitions for the 16-bit arithmetic sequencer that reuses the
//   core's 8-bit ALU:
//     - FSM state encoding
//     - request opcode encoding (req_op)
//     - ALU_Op constants driven onto the 8-bit ALU
//     - flag register bit indices (S7 Z6 Y5 H4 X3 P2 N1 C0)
//     - opcode -> ALU_Op mapping helpers for the low and high byte passes
package tv80_alu16_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_ADC16 = 2'b01,
        OP_SBC16 = 2'b10,
        OP_PASS  = 2'b11
    } op_t;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_ADC = 4'b0001;
    localparam logic [3:0] ALU_OP_SBC = 4'b0011;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_X = 3;
    localparam int FLAG_H = 4;
    localparam int FLAG_Y = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    // Low byte: ADD16 starts without carry, ADC16/SBC16 fold in the incoming C.
    function automatic logic [3:0] alu_op_lo(input op_t op);
        logic [3:0] r;
        case (op)
            OP_ADD16: r = ALU_OP_ADD;
            OP_ADC16: r = ALU_OP_ADC;
            OP_SBC16: r = ALU_OP_SBC;
            default:  r = ALU_OP_ADD;
        endcase
        return r;
    endfunction

    // High byte always propagates the carry/borrow out of the low byte.
    function automatic logic [3:0] alu_op_hi(input op_t op);
        logic [3:0] r;
        case (op)
            OP_SBC16: r = ALU_OP_SBC;
            default:  r = ALU_OP_ADC;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq
//   Sequences a 16-bit ADD/ADC/SBC (or a PASS) through the core's existing
//   8-bit ALU as a low-byte pass followed by a high-byte pass. The ALU itself
//   lives outside this block; this module only drives its inputs and captures
//   its outputs.
//
//   Optional feature: define TV80_ALU16_SEQ_REGIN_EN to register alu_q and
//   alu_fout before capture. Each byte pass then takes two cycles (drive,
//   capture). PASS is unaffected.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op                  00 ADD16, 01 ADC16, 10 SBC16, 11 PASS
//   req_a, req_b, f_in      operands (HL, rr) and flags at request time
//   rsp_valid/rsp_ready     response handshake
//   rsp_q, rsp_f            16-bit result and resulting flags
//   alu_op, alu_arith16,
//   alu_z16, alu_busa,
//   alu_busb, alu_fin       drive the 8-bit ALU (zero in IDLE and RSP)
//   alu_q, alu_fout         8-bit ALU result and flags
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request
// LO    | low bytes on the ALU, capture q[7:0] and low-pass flags
// HI    | high bytes on the ALU, capture q[15:8] and high-pass flags
// RSP   | response valid and held until rsp_ready
module tv80_alu16_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  f_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_q,
    output logic [7:0]  rsp_f,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_fin,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_fout
);

    import tv80_alu16_seq_pkg::*;

    state_t      state;
    state_t      state_nxt;

    op_t         op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [7:0]  f_r;
    logic [15:0] q_r;
    logic [7:0]  flo_r;
    logic [7:0]  fhi_r;

    // cap_en marks the cycle in which a byte pass result is taken.
    logic        cap_en;
    logic [7:0]  cap_q;
    logic [7:0]  cap_f;

`ifdef TV80_ALU16_SEQ_REGIN_EN
    logic        phase_r;
    logic [7:0]  alu_q_r;
    logic [7:0]  alu_fout_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r    <= 1'b0;
            alu_q_r    <= 8'h00;
            alu_fout_r <= 8'h00;
        end else begin
            alu_q_r    <= alu_q;
            alu_fout_r <= alu_fout;
            if (state == ST_LO || state == ST_HI)
                phase_r <= ~phase_r;
            else
                phase_r <= 1'b0;
        end
    end

    assign cap_en = phase_r;
    assign cap_q  = alu_q_r;
    assign cap_f  = alu_fout_r;
`else
    assign cap_en = 1'b1;
    assign cap_q  = alu_q;
    assign cap_f  = alu_fout;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_op      = 4'h0;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_fin     = 8'h00;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (op_t'(req_op) == OP_PASS) ? ST_RSP : ST_LO;
            end
            ST_LO: begin
                alu_op   = alu_op_lo(op_r);
                alu_busa = a_r[7:0];
                alu_busb = b_r[7:0];
                alu_fin  = f_r;
                if (cap_en)
                    state_nxt = ST_HI;
            end
            ST_HI: begin
                alu_op      = alu_op_hi(op_r);
                alu_arith16 = (op_r == OP_ADD16);
                alu_z16     = (op_r == OP_ADC16) || (op_r == OP_SBC16);
                alu_busa    = a_r[15:8];
                alu_busb    = b_r[15:8];
                alu_fin     = flo_r;
                if (cap_en)
                    state_nxt = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r  <= OP_ADD16;
            a_r   <= 16'h0000;
            b_r   <= 16'h0000;
            f_r   <= 8'h00;
            q_r   <= 16'h0000;
            flo_r <= 8'h00;
            fhi_r <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r <= op_t'(req_op);
                        a_r  <= req_a;
                        b_r  <= req_b;
                        f_r  <= f_in;
                        // PASS bypasses the ALU; result is ready immediately.
                        if (op_t'(req_op) == OP_PASS) begin
                            q_r   <= req_a;
                            fhi_r <= f_in;
                        end
                    end
                end
                ST_LO: begin
                    if (cap_en) begin
                        q_r[7:0] <= cap_q;
                        flo_r    <= cap_f;
                    end
                end
                ST_HI: begin
                    if (cap_en) begin
                        q_r[15:8] <= cap_q;
                        fhi_r     <= cap_f;
                    end
                end
                default: ;
            endcase
        end
    end

    // ADD HL,rr leaves S, Z and P/V untouched, so those come from the
    // flags presented with the request rather than from the ALU.
    always_comb begin
        rsp_f = fhi_r;
        if (op_r == OP_ADD16) begin
            rsp_f[FLAG_S] = f_r[FLAG_S];
            rsp_f[FLAG_Z] = f_r[FLAG_Z];
            rsp_f[FLAG_P] = f_r[FLAG_P];
        end
    end

    assign rsp_q = q_r;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
module tb_tv80_alu16_seq;

`ifdef TV80_ALU16_SEQ_REGIN_EN
    localparam int LAT  = 5;
    localparam int HI_J = 3;
`else
    localparam int LAT  = 3;
    localparam int HI_J = 2;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  f_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_q;
    logic [7:0]  rsp_f;
    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_fin;
    logic [7:0]  alu_q;
    logic [7:0]  alu_fout;

    int n_vec = 0;
    int n_err = 0;

    tv80_alu16_seq dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .f_in(f_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_f(rsp_f),
        .alu_op(alu_op), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
        .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_fin(alu_fin),
        .alu_q(alu_q), .alu_fout(alu_fout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core's 8-bit ALU (ADD/ADC/SBC subset with Arith16/Z16).
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] fi,
                                              input logic ar16, input logic z16);
        logic [8:0] s9;
        logic [4:0] h5;
        logic       cin, sub, v;
        logic [7:0] f;
        if (op != 4'b0000 && op != 4'b0001 && op != 4'b0011) return 16'h0000;
        cin = (op == 4'b0000) ? 1'b0 : fi[0];
        sub = op[1];
        if (!sub) begin
            s9 = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            h5 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin};
            v  = (a[7] == b[7]) && (s9[7] != a[7]);
        end else begin
            s9 = {1'b0, a} - {1'b0, b} - {8'h00, cin};
            h5 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, cin};
            v  = (a[7] != b[7]) && (s9[7] != a[7]);
        end
        f[7] = s9[7];
        f[6] = (s9[7:0] == 8'h00) ? (z16 ? fi[6] : 1'b1) : 1'b0;
        f[5] = s9[5];
        f[4] = h5[4];
        f[3] = s9[3];
        f[2] = v;
        f[1] = sub;
        f[0] = s9[8];
        if (ar16) begin
            f[7] = fi[7];
            f[6] = fi[6];
            f[2] = fi[2];
        end
        return {s9[7:0], f};
    endfunction

    always_comb {alu_q, alu_fout} = alu_model(alu_op, alu_busa, alu_busb, alu_fin, alu_arith16, alu_z16);

    // Drives one request and returns how many edges after the accept edge
    // rsp_valid is first seen (1 = at edge N+1); -1 if it never appears.
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] f, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; f_in = f;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({req_ready, rsp_valid, rsp_q, rsp_f} !== {1'b1, 1'b0, 16'h0000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b q=%h f=%h, want rdy=1 vld=0 q=0000 f=00",
                     req_ready, rsp_valid, rsp_q, rsp_f);
        end
        n_vec++;
        if ({alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_fin} !== 30'h0) begin
            n_err++;
            $display("FAIL reset_alu_drive: got op=%h a16=%b z16=%b a=%h b=%h fin=%h, want all 0",
                     alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_fin);
        end
    endtask

    task automatic test_add16();
        logic [29:0] snap [1:12];
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 16'h7FFF; req_b = 16'h0001; f_in = 8'h00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            snap[j] = {alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_fin};
            if (rsp_valid) begin
                lat = j;
                break;
            end
        end
        n_vec++;
        if (snap[1] !== {4'h0, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00}) begin
            n_err++;
            $display("FAIL add16_lo_drive: got %h, want %h", snap[1], {4'h0, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00});
        end
        n_vec++;
        if (snap[HI_J] !== {4'h1, 1'b1, 1'b0, 8'h7F, 8'h00, 8'h51}) begin
            n_err++;
            $display("FAIL add16_hi_drive: got %h, want %h", snap[HI_J], {4'h1, 1'b1, 1'b0, 8'h7F, 8'h00, 8'h51});
        end
        n_vec++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL add16_latency: got %0d, want %0d", lat, LAT);
        end
        n_vec++;
        if ({rsp_q, rsp_f, req_ready} !== {16'h8000, 8'h10, 1'b0}) begin
            n_err++;
            $display("FAIL add16_result: got q=%h f=%h rdy=%b, want q=8000 f=10 rdy=0", rsp_q, rsp_f, req_ready);
        end
        n_vec++;
        if ({alu_op, alu_busa, alu_busb, alu_fin} !== 28'h0) begin
            n_err++;
            $display("FAIL add16_rsp_alu_idle: got op=%h a=%h b=%h fin=%h, want 0", alu_op, alu_busa, alu_busb, alu_fin);
        end
        release_rsp();
    endtask

    task automatic test_adc16();
        int lat;
        issue(2'b01, 16'hFFFF, 16'h0001, 8'h00, lat);
        n_vec++;
        if ({lat == LAT, rsp_q, rsp_f} !== {1'b1, 16'h0000, 8'h51}) begin
            n_err++;
            $display("FAIL adc16: got lat=%0d q=%h f=%h, want lat=%0d q=0000 f=51", lat, rsp_q, rsp_f, LAT);
        end
        release_rsp();
    endtask

    task automatic test_sbc16();
        int lat;
        issue(2'b10, 16'h1000, 16'h0001, 8'h00, lat);
        n_vec++;
        if ({lat == LAT, rsp_q, rsp_f} !== {1'b1, 16'h0FFF, 8'h1A}) begin
            n_err++;
            $display("FAIL sbc16: got lat=%0d q=%h f=%h, want lat=%0d q=0FFF f=1A", lat, rsp_q, rsp_f, LAT);
        end
        release_rsp();
    endtask

    task automatic test_pass_hold();
        int lat;
        issue(2'b11, 16'h1234, 16'hBEEF, 8'hC5, lat);
        n_vec++;
        if ({lat, rsp_q, rsp_f} !== {32'sd1, 16'h1234, 8'hC5}) begin
            n_err++;
            $display("FAIL pass_result: got lat=%0d q=%h f=%h, want lat=1 q=1234 f=C5", lat, rsp_q, rsp_f);
        end
        // Hold off the consumer and throw extra requests at the busy block.
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_op = 2'b00; req_a = 16'h5555; req_b = 16'h1111; f_in = 8'hFF;
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, req_ready, rsp_q, rsp_f, alu_op, alu_busa} !== {1'b1, 1'b0, 16'h1234, 8'hC5, 4'h0, 8'h00}) begin
                n_err++;
                $display("FAIL pass_hold[%0d]: got vld=%b rdy=%b q=%h f=%h op=%h a=%h, want vld=1 rdy=0 q=1234 f=C5 op=0 a=00",
                         k, rsp_valid, req_ready, rsp_q, rsp_f, alu_op, alu_busa);
            end
        end
        req_valid = 1'b0;
        release_rsp();
        @(negedge clk);
        n_vec++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL pass_release: got rdy=%b vld=%b, want rdy=1 vld=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_a = 16'h1000; req_b = 16'h0001; f_in = 8'h00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int j = 1; j <= HI_J; j++) @(negedge clk);
        n_vec++;
        if (alu_busa !== 8'h10) begin
            n_err++;
            $display("FAIL abort_in_hi: got busa=%h, want 10", alu_busa);
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_q, rsp_f, alu_op} !== {1'b1, 1'b0, 16'h0000, 8'h00, 4'h0}) begin
            n_err++;
            $display("FAIL abort_reset_now: got rdy=%b vld=%b q=%h f=%h op=%h, want rdy=1 vld=0 q=0000 f=00 op=0",
                     req_ready, rsp_valid, rsp_q, rsp_f, alu_op);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_rsp: got busy/valid after reset=%b, want 0", seen);
        end
        issue(2'b01, 16'hFFFF, 16'h0001, 8'h00, lat);
        n_vec++;
        if ({lat == LAT, rsp_q, rsp_f} !== {1'b1, 16'h0000, 8'h51}) begin
            n_err++;
            $display("FAIL abort_next_op: got lat=%0d q=%h f=%h, want lat=%0d q=0000 f=51", lat, rsp_q, rsp_f, LAT);
        end
        release_rsp();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        f_in      = 8'h00;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_add16();
        test_adc16();
        test_sbc16();
        test_pass_hold();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, want completion before 200000");
        $fatal(1);
    end

endmodule
